// File: rtl/fir_host_ctrl.sv
// fir_host_ctrl
//   Initiator for the FIR filter's addr/x/operation/y/done port. One frame of
//   SIGNAL_LENGTH samples is taken from an input valid/ready stream and written
//   into the filter (op 01). The filter is then run (op 10) until it reports
//   done. Finally every result is read back (op 11) and presented on an output
//   valid/ready stream.
//
//   Optional feature macro: FIR_CTRL_TIMEOUT_EN
//     defined   : COMPUTE is bounded by TIMEOUT_CYCLES. On expiry err is set,
//                 the filter is pulsed into reset and the frame is dropped.
//     undefined : COMPUTE waits for f_done indefinitely and err is constant 0.
//
// Ports
//   clk, reset        clock (rising edge) and asynchronous active-high reset
//   start             pulse in IDLE begins a frame, ignored while busy
//   busy              high in every state except IDLE
//   in_valid/in_ready/in_data     upstream sample stream (in_ready only in LOAD)
//   out_valid/out_ready/out_data  downstream result stream
//   f_reset           filter synchronous reset
//   f_addr, f_x       filter sample/result index and write data (zero-extended)
//   f_operation       00 idle, 01 write, 10 compute, 11 read
//   f_y, f_done       filter read data (1 cycle after op 11) and compute-done level
//   err               sticky timeout flag, cleared by start
//
// Every output comes straight from a flop. The next-state logic computes the
// outputs for the state being entered, so each state's filter operation is on
// the bus during the cycle spent in that state. The only exception is a LOAD
// write: it is driven in the cycle after its input handshake, because it
// carries that handshake's data.

module fir_host_ctrl #(
  parameter int SIGNAL_LENGTH  = 1000,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              f_reset,
  output logic [31:0]       f_addr,
  output logic [31:0]       f_x,
  output logic [1:0]        f_operation,
  input  logic [31:0]       f_y,
  input  logic              f_done,
  output logic              err
);

  localparam int KW = $clog2(SIGNAL_LENGTH) + 1;
  localparam logic [KW-1:0] K_LAST = KW'(SIGNAL_LENGTH - 1);

  localparam logic [1:0] OP_IDLE    = 2'b00;
  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam logic [1:0] OP_COMPUTE = 2'b10;
  localparam logic [1:0] OP_READ    = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_COMPUTE,
    S_READ_ISSUE,
    S_READ_WAIT
  } state_t;

  state_t            state, state_next;
  logic [KW-1:0]     k, k_next;
  logic [KW-1:0]     k_inc;
  logic              busy_next;
  logic              in_ready_next;
  logic              out_valid_next;
  logic [DATA_W-1:0] out_data_next;
  logic              f_reset_next;
  logic [31:0]       f_addr_next;
  logic [31:0]       f_x_next;
  logic [1:0]        f_operation_next;
  logic              err_flag, err_flag_next;

`ifdef FIR_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tcnt, tcnt_next;
`endif

  assign k_inc = k + 1'b1;

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      k           <= '0;
      busy        <= 1'b0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      f_reset     <= 1'b1;
      f_addr      <= '0;
      f_x         <= '0;
      f_operation <= OP_IDLE;
      err_flag    <= 1'b0;
`ifdef FIR_CTRL_TIMEOUT_EN
      tcnt        <= '0;
`endif
    end else begin
      state       <= state_next;
      k           <= k_next;
      busy        <= busy_next;
      in_ready    <= in_ready_next;
      out_valid   <= out_valid_next;
      out_data    <= out_data_next;
      f_reset     <= f_reset_next;
      f_addr      <= f_addr_next;
      f_x         <= f_x_next;
      f_operation <= f_operation_next;
      err_flag    <= err_flag_next;
`ifdef FIR_CTRL_TIMEOUT_EN
      tcnt        <= tcnt_next;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_next       = state;
    k_next           = k;
    out_valid_next   = out_valid;
    out_data_next    = out_data;
    f_addr_next      = f_addr;
    f_x_next         = f_x;
    f_operation_next = OP_IDLE;
    f_reset_next     = 1'b0;
    err_flag_next    = err_flag;
`ifdef FIR_CTRL_TIMEOUT_EN
    // Counts the cycles spent in COMPUTE. It restarts at zero on every entry.
    tcnt_next        = (state == S_COMPUTE) ? tcnt + 1'b1 : '0;
`endif

    case (state)
      S_IDLE: begin
        if (start) begin
          state_next    = S_CLEAR;
          k_next        = '0;
          err_flag_next = 1'b0;
        end
      end

      S_CLEAR: begin
        state_next = S_LOAD;
      end

      S_LOAD: begin
        if (in_valid && in_ready) begin
          f_operation_next = OP_WRITE;
          f_addr_next      = 32'(k);
          f_x_next         = 32'(in_data);
          if (k == K_LAST) begin
            k_next     = '0;
            state_next = S_COMPUTE;
          end else begin
            k_next = k_inc;
          end
        end
      end

      S_COMPUTE: begin
        if (f_done) begin
          // The filter stops advancing as soon as op leaves 10. The first
          // read goes out right away.
          state_next       = S_READ_ISSUE;
          f_operation_next = OP_READ;
          f_addr_next      = 32'(k);
        end else begin
          f_operation_next = OP_COMPUTE;
`ifdef FIR_CTRL_TIMEOUT_EN
          if (tcnt == T_LAST) begin
            // Abandon the frame. The filter gets a one-cycle reset and no
            // results are produced.
            state_next       = S_IDLE;
            f_operation_next = OP_IDLE;
            f_reset_next     = 1'b1;
            err_flag_next    = 1'b1;
          end
`endif
        end
      end

      S_READ_ISSUE: begin
        // op 11 is on the bus during this cycle. f_y is valid in READ_WAIT.
        state_next = S_READ_WAIT;
      end

      S_READ_WAIT: begin
        if (!out_valid) begin
          out_data_next  = f_y[DATA_W-1:0];
          out_valid_next = 1'b1;
        end else if (out_ready) begin
          out_valid_next = 1'b0;
          if (k == K_LAST) begin
            state_next = S_IDLE;
          end else begin
            k_next           = k_inc;
            state_next       = S_READ_ISSUE;
            f_operation_next = OP_READ;
            f_addr_next      = 32'(k_inc);
          end
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    if (state_next == S_CLEAR) begin
      f_reset_next = 1'b1;
    end
  end

  assign busy_next     = (state_next != S_IDLE);
  assign in_ready_next = (state_next == S_LOAD);

`ifdef FIR_CTRL_TIMEOUT_EN
  assign err = err_flag;
`else
  // No timeout hardware. The flag register never sets, and this expression
  // is 0 for every legal (positive) TIMEOUT_CYCLES.
  assign err = err_flag | (TIMEOUT_CYCLES < 0);
`endif

endmodule
